// File: rtl/column_window_gen_pkg.sv
// Shared constants and helpers for the 7-row column window generator and the
// downstream orientation stage, so both agree on column packing.
package column_window_gen_pkg;

    localparam int WIN        = 7;
    localparam int PIX_W      = 8;
    localparam int COL_W      = WIN * PIX_W;
    localparam int NBUF       = WIN - 1;
    localparam int PTR_W      = $clog2(NBUF);
    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGHT = 480;
    localparam int ROW_OUT_W  = 9;
    localparam int COL_OUT_W  = 10;

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [PTR_W-1:0] ptr_t;

    // Next buffer slot in the 6-entry rotation.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(NBUF - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Slot that was written d rows before slot p.
    function automatic ptr_t ptr_back(input ptr_t p, input int d);
        int t;
        t = int'(p) + NBUF - d;
        return ptr_t'(t % NBUF);
    endfunction

endpackage

// File: rtl/column_window_gen_line_buffer_ram.sv
// Single-port line buffer, one pixel wide: read-before-write with a registered
// read port, so it maps onto block RAM with an output-register reset.
module line_buffer_ram
    import column_window_gen_pkg::*;
#(
    parameter int DEPTH = DEF_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  pix_t          i_wdata,
    output pix_t          o_rdata
);

    pix_t mem [DEPTH];
    pix_t rd_reg;

    always_ff @(posedge i_clk) begin
        if (i_en && i_we) begin
            mem[i_addr] <= i_wdata;
        end
    end

    // Only the output register is reset; the array itself keeps stale rows.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_reg <= '0;
        end else if (i_en) begin
            rd_reg <= mem[i_addr];
        end
    end

    assign o_rdata = rd_reg;

endmodule

// File: rtl/column_window_gen.sv
// Raster pixel stream to 7-tall vertical columns (rows r-6..r) with one cycle
// of latency, using six single-port line buffers.
module column_window_gen
    import column_window_gen_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_sof,
    input  logic                 i_valid,
    input  logic [PIX_W-1:0]     i_pixel,
    output logic                 o_valid,
    output logic                 o_win_ok,
    output logic [COL_W-1:0]     o_col0,
    output logic [ROW_OUT_W-1:0] o_row,
    output logic [COL_OUT_W-1:0] o_col
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    logic [CW-1:0] col_reg, col_next, cur_col;
    logic [RW-1:0] row_reg, row_next, cur_row;
    ptr_t          ptr_reg, ptr_next, cur_ptr;

    logic          valid_reg;
    logic          win_ok_reg;
    logic [RW-1:0] row_out_reg;
    logic [CW-1:0] col_out_reg;
    pix_t          pix_reg;
    ptr_t          ptr_out_reg;

    logic          ram_en;
    pix_t          rd_data [NBUF];

    // The buffers rotate roles per row instead of physically shifting data:
    // the slot being overwritten holds row r-6, which read-before-write still
    // returns. Logical buffer k is slot (cur_ptr-1-k) mod 6.
    always_comb begin
        cur_col  = i_sof ? '0 : col_reg;
        cur_row  = i_sof ? '0 : row_reg;
        cur_ptr  = (i_sof && col_reg != '0) ? ptr_inc(ptr_reg) : ptr_reg;
        col_next = col_reg;
        row_next = row_reg;
        ptr_next = ptr_reg;
        if (i_valid) begin
            if (cur_col == CW'(WIDTH - 1)) begin
                col_next = '0;
                ptr_next = ptr_inc(cur_ptr);
                row_next = (cur_row == RW'(HEIGHT - 1)) ? '0 : cur_row + RW'(1);
            end else begin
                col_next = cur_col + CW'(1);
                ptr_next = cur_ptr;
                row_next = cur_row;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_reg     <= '0;
            row_reg     <= '0;
            ptr_reg     <= '0;
            valid_reg   <= 1'b0;
            win_ok_reg  <= 1'b0;
            row_out_reg <= '0;
            col_out_reg <= '0;
            pix_reg     <= '0;
            ptr_out_reg <= '0;
        end else begin
            col_reg    <= col_next;
            row_reg    <= row_next;
            ptr_reg    <= ptr_next;
            valid_reg  <= i_valid;
            win_ok_reg <= i_valid && (int'(cur_row) >= WIN - 1);
            if (i_valid) begin
                row_out_reg <= cur_row;
                col_out_reg <= cur_col;
                pix_reg     <= i_pixel;
                ptr_out_reg <= cur_ptr;
            end
        end
    end

    assign ram_en = i_valid && !i_rst;

    genvar gi;
    generate
        for (gi = 0; gi < NBUF; gi++) begin : g_lb
            line_buffer_ram #(
                .DEPTH (WIDTH),
                .AW    (CW)
            ) u_lb (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_en    (ram_en),
                .i_we    (cur_ptr == ptr_t'(gi)),
                .i_addr  (cur_col),
                .i_wdata (i_pixel),
                .o_rdata (rd_data[gi])
            );
        end

        // Slot 0 (bits [7:0]) is the oldest row, slot 6 the current pixel.
        for (gi = 0; gi < NBUF; gi++) begin : g_pack
            assign o_col0[(NBUF-1-gi)*PIX_W +: PIX_W] = rd_data[ptr_back(ptr_out_reg, gi + 1)];
        end
    endgenerate

    assign o_col0[COL_W-1 -: PIX_W] = pix_reg;
    assign o_valid  = valid_reg;
    assign o_win_ok = win_ok_reg;
    assign o_row    = ROW_OUT_W'(row_out_reg);
    assign o_col    = COL_OUT_W'(col_out_reg);

endmodule

// File: tb/tb_column_window_gen.sv
// Randomized bench for column_window_gen against a frame-image reference model.
module tb_column_window_gen;

    localparam int W = 8;
    localparam int H = 10;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_sof = 1'b0;
    logic        i_valid = 1'b0;
    logic [7:0]  i_pixel = '0;
    logic        o_valid;
    logic        o_win_ok;
    logic [55:0] o_col0;
    logic [8:0]  o_row;
    logic [9:0]  o_col;

    column_window_gen #(.WIDTH(W), .HEIGHT(H)) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_sof    (i_sof),
        .i_valid  (i_valid),
        .i_pixel  (i_pixel),
        .o_valid  (o_valid),
        .o_win_ok (o_win_ok),
        .o_col0   (o_col0),
        .o_row    (o_row),
        .o_col    (o_col)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;
    int out_cnt       = 0;

    // Reference model: image of the frame in progress plus expected position.
    logic [7:0]  img [H][W];
    int          m_row, m_col;
    int          last_row, last_col;
    logic [7:0]  last_pix;
    logic [55:0] last_exp;
    bit          last_full;

    always @(negedge clk) if (o_valid) out_cnt++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got !== exp) begin
            $display("FAIL %s: got=%0h expected=%0h (row %0d col %0d)", tag, got, exp, m_row, m_col);
        end else begin
            checks_passed++;
        end
    endtask

    function automatic logic [55:0] exp_window(input int r, input int c);
        logic [55:0] v;
        for (int k = 0; k < 7; k++) v[k*8 +: 8] = img[r-6+k][c];
        return v;
    endfunction

    task automatic send(input bit sof, input logic [7:0] pix);
        int r, c;
        r = sof ? 0 : m_row;
        c = sof ? 0 : m_col;
        img[r][c] = pix;
        i_sof = sof; i_valid = 1'b1; i_pixel = pix;
        @(posedge clk); #1;
        i_sof = 1'b0; i_valid = 1'b0;
        chk("valid", o_valid, 1);
        chk("row", o_row, r);
        chk("col", o_col, c);
        chk("win_ok", o_win_ok, r >= 6);
        chk("bottom", o_col0[55:48], pix);
        if (r >= 6) chk("window", o_col0, exp_window(r, c));
        $display("px sof=%0b r=%0d c=%0d in=%02h out=%014h ok=%0b", sof, r, c, pix, o_col0, o_win_ok);
        last_row = r; last_col = c; last_pix = pix;
        last_full = (r >= 6);
        if (r >= 6) last_exp = exp_window(r, c);
        if (c == W - 1) begin
            m_col = 0;
            m_row = (r + 1) % H;
        end else begin
            m_col = c + 1;
            m_row = r;
        end
    endtask

    task automatic idle(input bit sof);
        i_sof = sof; i_valid = 1'b0; i_pixel = 8'($urandom);
        @(posedge clk); #1;
        i_sof = 1'b0;
        chk("gap_valid", o_valid, 0);
        chk("gap_win_ok", o_win_ok, 0);
        chk("gap_row", o_row, last_row);
        chk("gap_col", o_col, last_col);
        chk("gap_bottom", o_col0[55:48], last_pix);
        if (last_full) chk("gap_window", o_col0, last_exp);
        $display("gap sof=%0b out=%014h", sof, o_col0);
    endtask

    task automatic do_reset(input int n, input bit valid);
        i_rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            i_valid = valid; i_pixel = 8'($urandom);
            @(posedge clk); #1;
            chk("rst_valid", o_valid, 0);
            chk("rst_win_ok", o_win_ok, 0);
            chk("rst_col0", o_col0, 0);
            chk("rst_row", o_row, 0);
            chk("rst_col", o_col, 0);
            $display("rst cycle %0d valid_in=%0b", i, valid);
        end
        i_rst = 1'b0; i_valid = 1'b0;
        m_row = 0; m_col = 0;
        last_row = 0; last_col = 0; last_pix = '0;
        last_full = 1'b1; last_exp = '0;
    endtask

    initial begin
        int in_cnt, out0;
        m_row = 0; m_col = 0;

        do_reset(3, 1'b1);

        // Ramp frame: pixel = 16*row + col
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send(r == 0 && c == 0, 8'(16 * r + c));
                if (r == 6 && c == 3) begin
                    chk("ramp_r6c3", o_col0, 56'h63534333231303);
                    chk("ramp_r6c3_ok", o_win_ok, 1);
                end
            end
        end

        // Frame wrap: pixel after (9,7) must be (0,0)
        send(1'b0, 8'($urandom));
        chk("wrap_row", o_row, 0);
        chk("wrap_col", o_col, 0);

        // Two frames of random pixels with random bubbles; some gaps carry a stray sof
        in_cnt = 1;
        out0 = out_cnt - 1;
        for (int i = 1; i < 2 * W * H; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                int g;
                g = int'($urandom_range(1, 5));
                for (int j = 0; j < g; j++) idle($urandom_range(0, 3) == 0);
            end
            send(1'b0, 8'($urandom));
            in_cnt++;
        end
        #1;
        chk("valid_count", out_cnt - out0, in_cnt);

        // Mid-frame sof at (4,5)
        send(1'b1, 8'($urandom));
        while (!(m_row == 4 && m_col == 5)) send(1'b0, 8'($urandom));
        send(1'b1, 8'($urandom));
        chk("sof_row", o_row, 0);
        chk("sof_col", o_col, 0);
        while (m_row != 7) send(1'b0, 8'($urandom));

        // Reset pulse before (7,2); next pixel without sof restarts at (0,0)
        while (!(m_row == 7 && m_col == 2)) send(1'b0, 8'($urandom));
        do_reset(1, 1'b0);
        send(1'b0, 8'($urandom));
        chk("rst_mid_row", o_row, 0);
        chk("rst_mid_col", o_col, 0);
        while (m_row != 8) send(1'b0, 8'($urandom));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/column_window_gen.md
COLUMN_WINDOW_GEN -- requirements
Module: column_window_gen

Interface
REQ-001 Parameter WIDTH, 640, pixels per image row.
REQ-002 Parameter HEIGHT, 480, rows per frame.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_sof  input  1  start-of-frame pulse, qualified by i_valid, marks pixel (row 0, col 0).
REQ-006 i_valid  input  1  i_pixel carries a raster-order pixel this cycle.
REQ-007 i_pixel  input  8  unsigned grey pixel.
REQ-008 o_valid  output  1  o_col0 / o_row / o_col are meaningful this cycle.
REQ-009 o_win_ok  output  1  o_col0 holds 7 real rows (current row index >= 6).
REQ-010 o_col0  output  56  7-pixel vertical column, bits [7:0] = top (row r-6), bits [55:48] = bottom (row r, current pixel).
REQ-011 o_row  output  9  row index r of the bottom pixel.
REQ-012 o_col  output  10  column index of the column.

Function
REQ-013 The block SHALL keep 6 line buffers of WIDTH x 8 bits; buffer k holds row r-1-k.
REQ-014 On each i_valid cycle, the block SHALL read all 6 buffers at the current column and write a shifted column: buffer 0 takes i_pixel, buffer k takes the old value of buffer k-1.
REQ-015 A read and a write to the same address in the same cycle SHALL return the old data (read-before-write).
REQ-016 Latency SHALL be exactly 1 cycle: o_valid is i_valid delayed by one cycle, and o_col0/o_row/o_col belong to that pixel.
REQ-017 On cycles with i_valid=0, the column counter, row counter and buffers SHALL hold; o_valid SHALL be 0 and the other outputs SHALL hold their previous values.
REQ-018 The column counter SHALL increment per valid pixel and wrap from WIDTH-1 to 0; on the wrap, the row counter SHALL increment.
REQ-019 The row counter SHALL wrap from HEIGHT-1 to 0 after the last pixel of a frame.
REQ-020 When i_sof=1 and i_valid=1, the pixel SHALL be treated as (0,0) and the counters SHALL be forced, including mid-frame.
REQ-021 Buffer contents SHALL not be cleared by i_sof.
REQ-022 o_win_ok SHALL be 1 only when o_valid=1 and o_row >= 6.
REQ-023 i_sof with i_valid=0 SHALL be ignored.
REQ-024 No backpressure is provided; the downstream orientation stage consumes one column per o_valid cycle.
REQ-025 Counter widths: the column counter SHALL be ceil(log2 WIDTH) bits and the row counter ceil(log2 HEIGHT) bits, with no overflow beyond the wrap points.

Reset
REQ-026 While i_rst=1 at a clock edge, the counters SHALL be set to 0, and o_valid, o_win_ok, o_col0, o_row and o_col SHALL be set to 0.
REQ-027 Line buffer RAM contents SHALL NOT be reset; o_win_ok gating guarantees stale data is never flagged valid.
REQ-028 Reset asserted mid-frame SHALL discard the frame; the next valid pixel SHALL be treated as (0,0), whether or not i_sof is set.

Structure
REQ-029 A shared package SHALL hold the following constants:
- WIN = 7
- PIX_W = 8
- COL_W = WIN*PIX_W = 56
- defaults for WIDTH and HEIGHT, so the orientation stage and this block agree on column packing.
REQ-030 One sub-module, line_buffer_ram, SHALL be used:
- single-port, depth WIDTH, width 8
- read-before-write
- instantiated 6 times
- inferable as SRAM

Verification
REQ-031 Reset: hold i_rst=1 for 3 cycles with i_valid=1 -> o_valid=0, o_col0=0, o_row=0, o_col=0 throughout.
REQ-032 Ramp frame: WIDTH=8, HEIGHT=10, pixel = 16*row+col.
- At the row-6, col-3 output: o_col0 = {0x63,0x53,0x43,0x33,0x23,0x13,0x03} (MSB first) and o_win_ok=1.
- For all rows < 6: o_win_ok=0.
REQ-033 Bubbles: insert i_valid=0 gaps of 1-5 cycles at random.
- o_col0 sequence is identical to the gap-free run.
- o_valid count equals the input valid count.
- Outputs hold during gaps.
REQ-034 Wrap: with WIDTH=8 and HEIGHT=10, after pixel (9,7) the next valid pixel -> o_row=0, o_col=0, o_win_ok=0.
REQ-035 Mid-frame sof: assert i_sof at (4,5) -> that output shows o_row=0, o_col=0; o_win_ok stays 0 until the new row 6.
REQ-036 Reset mid-frame: pulse i_rst at (7,2) -> the next valid pixel (without sof) is reported as (0,0), and o_win_ok=0 until row 6.
